// File: rtl/branch_resolve.sv
// Resolves beq/bne/jr in ID using forwarded operands; holds PC and IF/ID during hazard stalls.
// Latency: resolve in cycle N -> registered pc_redirect/ifid_flush pulse in cycle N+1 (2-cycle taken penalty).
// Backpressure: stall_j on a control instruction holds PC/IF/ID and bubbles ID/EX until it drops.
module branch_resolve #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STALL_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_bne,
    input  logic              id_jumpr,
    input  logic [ADDR_W-1:0] id_pc_plus4,
    input  logic [15:0]       id_imm,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic [1:0]        fwd_ja,
    input  logic [1:0]        fwd_jb,
    input  logic              stall_j,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              ifid_flush,
    output logic              stall_overflow,
    output logic [15:0]       taken_count
);

    // Counter must be able to hold STALL_MAX+1, its saturation value.
    localparam int CNT_W = $clog2(STALL_MAX + 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [ADDR_W-1:0] pc_target_q, pc_target_d;
    logic              stall_overflow_q, stall_overflow_d;
    logic [15:0]       taken_count_q, taken_count_d;

    logic              ctl;
    logic              is_jr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              taken;
    logic [ADDR_W-1:0] br_offset;
    logic [ADDR_W-1:0] target;
    logic              in_id_state;
    logic              hold;
    logic              resolve;

    // Operand selection and branch/jump evaluation; jr wins if both decode bits are set.
    always_comb begin
        ctl       = id_valid & (id_branch | id_jumpr);
        is_jr     = id_jumpr;
        // Only encoding 01 forwards; 1x falls back to the register file.
        op_a      = (fwd_ja == 2'b01) ? exmem_alu_result : rs_data;
        op_b      = (fwd_jb == 2'b01) ? exmem_alu_result : rt_data;
        br_offset = {{(ADDR_W-16){id_imm[15]}}, id_imm} << 2;
        if (is_jr) begin
            taken  = 1'b1;
            target = op_a[ADDR_W-1:0];
        end else begin
            taken  = id_bne ? (op_a != op_b) : (op_a == op_b);
            target = id_pc_plus4 + br_offset;
        end
    end

    // Hold is only meaningful while the ID slot is live; the REDIRECT cycle ignores ID.
    always_comb begin
        in_id_state = (state_q == IDLE) || (state_q == STALL);
        hold        = in_id_state & ctl & stall_j;
    end

    // Next-state logic: stall tracking, resolve, target latch and taken counter.
    always_comb begin
        state_d          = state_q;
        stall_cnt_d      = stall_cnt_q;
        pc_target_d      = pc_target_q;
        stall_overflow_d = stall_overflow_q;
        taken_count_d    = taken_count_q;
        resolve          = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctl) begin
                    if (stall_j) begin
                        state_d     = STALL;
                        stall_cnt_d = CNT_W'(1);
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            STALL: begin
                if (!ctl) begin
                    // Instruction vanished from ID while waiting: abandon, no redirect.
                    state_d     = IDLE;
                    stall_cnt_d = '0;
                end else if (stall_j) begin
                    if (stall_cnt_q >= CNT_W'(STALL_MAX)) begin
                        stall_overflow_d = 1'b1;
                    end
                    if (stall_cnt_q < CNT_W'(STALL_MAX + 1)) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end
                end else begin
                    resolve     = 1'b1;
                    stall_cnt_d = '0;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                stall_cnt_d = '0;
            end
        endcase

        if (resolve) begin
            pc_target_d = target;
            if (taken) begin
                state_d = REDIRECT;
                if (taken_count_q != 16'hFFFF) begin
                    taken_count_d = taken_count_q + 16'd1;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            stall_cnt_q      <= '0;
            pc_target_q      <= '0;
            stall_overflow_q <= 1'b0;
            taken_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            stall_cnt_q      <= stall_cnt_d;
            pc_target_q      <= pc_target_d;
            stall_overflow_q <= stall_overflow_d;
            taken_count_q    <= taken_count_d;
        end
    end

    // Outputs are forced low while rst is high, even before the reset edge lands.
    always_comb begin
        pc_hold        = ~rst & hold;
        ifid_hold      = ~rst & hold;
        // Bubble also squashes the wrong-path instruction sitting in ID during REDIRECT.
        idex_bubble    = ~rst & (hold | (state_q == REDIRECT));
        pc_redirect    = ~rst & (state_q == REDIRECT);
        ifid_flush     = ~rst & (state_q == REDIRECT);
        pc_target      = rst ? '0 : pc_target_q;
        stall_overflow = ~rst & stall_overflow_q;
        taken_count    = rst ? '0 : taken_count_q;
    end

endmodule
